tsu_queue_reader: RTL and testbench
===================================

TSU_QUEUE_READER -- requirements
Module: tsu_queue_reader

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1: q_rd_clk cycles from q_rd_en high to q_rd_data valid; legal range 1..3.
REQ-002 SHALL have parameter CNT_W, default 16: width of the delivered-entry counter.
REQ-003 SHALL have port q_rd_clk, input, 1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port q_rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port q_rd_en, output, 1: pop strobe to the tsu timestamp queue.
REQ-006 SHALL have port q_rd_stat, input, 8: number of entries in the tsu queue; 0 means empty.
REQ-007 SHALL have port q_rd_data, input, 128: queue entry, valid RD_LATENCY cycles after q_rd_en.
REQ-008 SHALL have port flush, input, 1: synchronous discard of the held entry.
REQ-009 SHALL have port out_valid, output, 1: out_data holds a valid word.
REQ-010 SHALL have port out_ready, input, 1: the consumer accepts the word.
REQ-011 SHALL have port out_data, output, 32: one word of the held entry.
REQ-012 SHALL have port out_last, output, 1: high with word 3, the final word of an entry.
REQ-013 SHALL have port ent_cnt, output, CNT_W: count of entries fully delivered.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, SEND.
REQ-015 IDLE: when q_rd_stat != 0 and flush = 0, SHALL drive q_rd_en high for exactly one cycle and enter WAIT; otherwise SHALL stay in IDLE with q_rd_en low.
REQ-016 WAIT: SHALL count RD_LATENCY cycles after the q_rd_en cycle, capture q_rd_data into a 128-bit holding register on the cycle it is valid, then enter SEND with word index 0.
REQ-017 SHALL never assert q_rd_en outside IDLE; at most one read SHALL be outstanding.
REQ-018 SEND: out_valid = 1; out_data = hold[127-32*idx -: 32], with idx 0..3, most significant word first; out_last = (idx == 3).
REQ-019 On out_valid && out_ready, SHALL advance idx in the same cycle; when idx == 3 SHALL increment ent_cnt and return to IDLE.
REQ-020 While out_ready = 0, out_data, out_last and idx SHALL hold stable.
REQ-021 ent_cnt SHALL saturate at all-ones and never wrap.
REQ-022 After leaving SEND, SHALL spend at least one cycle in IDLE before the next q_rd_en, so q_rd_stat reflects the previous pop.
REQ-023 Minimum throughput: one entry per 4 + 1 + RD_LATENCY cycles when out_ready is held high.
REQ-024 flush in SEND: SHALL drop out_valid the next cycle, discard the held entry, return to IDLE, and leave ent_cnt unchanged.
REQ-025 flush in WAIT: SHALL complete the outstanding read, discard the captured data, and return to IDLE without entering SEND.
REQ-026 flush in IDLE: SHALL suppress q_rd_en for that cycle.
REQ-027 flush and the final out_ready handshake in the same cycle: the handshake SHALL win; ent_cnt increments and the FSM enters IDLE.
REQ-028 q_rd_stat going to 0 while in WAIT SHALL NOT affect the outstanding capture.

Reset
REQ-029 q_rst_n low SHALL immediately force state IDLE, q_rd_en = 0, out_valid = 0, out_last = 0, out_data = 0, idx = 0, holding register = 0, ent_cnt = 0.
REQ-030 Reset asserted mid-WAIT or mid-SEND SHALL abandon the entry; the popped entry is lost, and no q_rd_en SHALL occur until the first clock edge after q_rst_n rises.

Verification
REQ-031 q_rd_stat = 1, entry 0x00112233_44556677_8899AABB_CCDDEEFF, out_ready = 1 -> single q_rd_en pulse; words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF; out_last on the 4th word; ent_cnt = 1.
REQ-032 q_rd_stat = 3, out_ready = 1 -> exactly 3 q_rd_en pulses spaced at least 6 cycles apart (RD_LATENCY = 1); 12 words; ent_cnt = 3; no q_rd_en once stat = 0.
REQ-033 out_ready toggling 1-0-0-1 during SEND -> out_data stable on stall cycles; all 4 words delivered in order; no duplicates.
REQ-034 flush asserted after word 1 is accepted -> out_valid = 0 next cycle; ent_cnt unchanged; the next entry starts at word 0.
REQ-035 q_rst_n pulsed low during WAIT -> all outputs 0 within the same cycle; after release with q_rd_stat = 2, normal drain resumes.
REQ-036 RD_LATENCY = 3 build, ent_cnt preset near saturation by delivering 2^CNT_W+1 entries (CNT_W = 4) -> correct data capture; ent_cnt = 0xF.

Source files
------------

// File: rtl/tsu_queue_reader.sv
// tsu_queue_reader
//   Pops timestamp entries from the TSU queue one at a time and streams each
//   128-bit entry to a consumer as four 32-bit words, most significant first.
//
// Parameters
//   RD_LATENCY  cycles from q_rd_en high to q_rd_data valid (1..3)
//   CNT_W       width of the delivered-entry counter
//
// Ports
//   q_rd_clk    clock, all logic on the rising edge
//   q_rst_n     asynchronous active-low reset
//   q_rd_en     pop strobe to the TSU queue (one cycle per entry)
//   q_rd_stat   queue occupancy, 0 = empty
//   q_rd_data   queue entry, valid RD_LATENCY cycles after q_rd_en
//   flush       synchronous discard of the entry in flight
//   out_valid   out_data holds a valid word
//   out_ready   consumer accepts the current word
//   out_data    current 32-bit word of the held entry
//   out_last    high with the final (fourth) word of an entry
//   ent_cnt     saturating count of entries fully delivered
module tsu_queue_reader #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             q_rd_clk,
  input  logic             q_rst_n,
  output logic             q_rd_en,
  input  logic [7:0]       q_rd_stat,
  input  logic [127:0]     q_rd_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] ent_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  state_t       state;
  logic [1:0]   idx;
  logic [1:0]   wait_cnt;
  logic [127:0] hold;
  logic         flush_pend;
  logic         rd_arm;

  // Word n of an entry, word 0 being the most significant.
  function automatic logic [31:0] word_sel(input logic [127:0] ent,
                                           input logic [1:0]   n);
    logic [31:0] w;
    case (n)
      2'd0:    w = ent[127:96];
      2'd1:    w = ent[95:64];
      2'd2:    w = ent[63:32];
      default: w = ent[31:0];
    endcase
    return w;
  endfunction

  // The pop strobe is issued in the IDLE cycle itself so that a full entry
  // takes 1 (pop) + RD_LATENCY + 4 (words) cycles. It is gated by flush in
  // the same cycle, and by rd_arm, which stays low until the first clock
  // edge after reset release so no pop can occur while coming out of reset.
  assign q_rd_en = rd_arm && (state == IDLE) && (q_rd_stat != '0) && !flush;

  always_ff @(posedge q_rd_clk or negedge q_rst_n) begin
    if (!q_rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      wait_cnt   <= '0;
      hold       <= '0;
      flush_pend <= 1'b0;
      rd_arm     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      ent_cnt    <= '0;
    end else begin
      rd_arm <= 1'b1;
      case (state)
        IDLE: begin
          if (q_rd_en) begin
            state      <= WAIT;
            wait_cnt   <= 2'd1;
            flush_pend <= 1'b0;
          end
        end

        WAIT: begin
          // wait_cnt == LAT marks the cycle q_rd_data is valid. A flush seen
          // anywhere in WAIT lets the read complete but drops the data.
          if (wait_cnt == LAT) begin
            if (flush || flush_pend) begin
              state <= IDLE;
            end else begin
              hold      <= q_rd_data;
              out_data  <= q_rd_data[127:96];
              out_valid <= 1'b1;
              out_last  <= 1'b0;
              idx       <= '0;
              state     <= SEND;
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
            if (flush) begin
              flush_pend <= 1'b1;
            end
          end
        end

        SEND: begin
          // The final handshake takes priority over a simultaneous flush.
          if (out_ready && (idx == 2'd3)) begin
            if (ent_cnt != '1) begin
              ent_cnt <= ent_cnt + CNT_W'(1);
            end
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            idx       <= '0;
            state     <= IDLE;
          end else if (flush) begin
            hold      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            idx       <= '0;
            state     <= IDLE;
          end else if (out_ready) begin
            idx      <= idx + 2'd1;
            out_data <= word_sel(hold, idx + 2'd1);
            out_last <= (idx == 2'd2);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tsu_queue_reader.sv
module tb_tsu_queue_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Main instance: RD_LATENCY = 1, CNT_W = 16
  logic         q_rd_en;
  logic [7:0]   q_rd_stat;
  logic [127:0] q_rd_data;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic [15:0]  ent_cnt;

  // Second instance: RD_LATENCY = 3, CNT_W = 4
  logic         q_rd_en2;
  logic [7:0]   q_rd_stat2;
  logic [127:0] q_rd_data2;
  logic         flush2;
  logic         out_valid2;
  logic         out_ready2;
  logic [31:0]  out_data2;
  logic         out_last2;
  logic [3:0]   ent_cnt2;

  tsu_queue_reader #(.RD_LATENCY(1), .CNT_W(16)) dut (
    .q_rd_clk (clk),
    .q_rst_n  (rst_n),
    .q_rd_en  (q_rd_en),
    .q_rd_stat(q_rd_stat),
    .q_rd_data(q_rd_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .ent_cnt  (ent_cnt)
  );

  tsu_queue_reader #(.RD_LATENCY(3), .CNT_W(4)) dut2 (
    .q_rd_clk (clk),
    .q_rst_n  (rst_n),
    .q_rd_en  (q_rd_en2),
    .q_rd_stat(q_rd_stat2),
    .q_rd_data(q_rd_data2),
    .flush    (flush2),
    .out_valid(out_valid2),
    .out_ready(out_ready2),
    .out_data (out_data2),
    .out_last (out_last2),
    .ent_cnt  (ent_cnt2)
  );

  localparam logic [127:0] GARB = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- queue model, main instance (latency 1) ----------------
  logic [127:0] qdata[$];
  int           n_push = 0;
  int           n_pop  = 0;
  logic [127:0] pipe1  = GARB;
  int           cyc    = 0;
  int           pulse_cyc[$];
  int           en_empty = 0;
  int           back2back = 0;
  logic         prev_en = 1'b0;

  assign q_rd_stat = 8'(n_push - n_pop);
  assign q_rd_data = pipe1;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (q_rd_en) begin
      pulse_cyc.push_back(cyc);
      if (q_rd_stat == 8'd0) en_empty = en_empty + 1;
      if (prev_en) back2back = back2back + 1;
      n_pop <= n_pop + 1;
      pipe1 <= qdata.pop_front();
    end else begin
      pipe1 <= GARB;
    end
    prev_en <= q_rd_en;
  end

  task automatic push(input logic [127:0] e);
    qdata.push_back(e);
    n_push++;
  endtask

  // ---------------- queue model, second instance (latency 3) --------------
  int           n_push2 = 0;
  int           n_pop2  = 0;
  logic [127:0] p2a = GARB, p2b = GARB, p2c = GARB;

  function automatic logic [31:0] w2(input int n, input int j);
    return 32'hC000_0000 | (32'(n) << 4) | 32'(j);
  endfunction

  function automatic logic [127:0] ent2(input int n);
    return {w2(n, 0), w2(n, 1), w2(n, 2), w2(n, 3)};
  endfunction

  assign q_rd_stat2 = 8'(n_push2 - n_pop2);
  assign q_rd_data2 = p2c;

  always @(posedge clk) begin
    if (q_rd_en2) begin
      n_pop2 <= n_pop2 + 1;
      p2a    <= ent2(n_pop2);
    end else begin
      p2a <= GARB;
    end
    p2b <= p2a;
    p2c <= p2b;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0]     entry;
    logic [7:0]       ready_pat;   // out_ready per valid cycle, bit 0 first
    logic             flush_last;  // raise flush with the final handshake
    logic [3:0][31:0] w;           // expected words in delivery order
  } vec_t;

  vec_t vecs[4];
  int   exp_ent = 0;

  function automatic logic [31:0] wb(input int k, input int j);
    return 32'hB000_0000 | (32'(k) << 8) | 32'(j);
  endfunction

  // Drains one entry, driving out_ready from the vector pattern and checking
  // every presented word (a stalled word is re-checked on the next cycle).
  task automatic collect(input vec_t v, input string tag);
    int widx = 0;
    int pi = 0;
    int t = 0;
    while (widx < 4 && t < 60) begin
      @(negedge clk);
      t++;
      if (out_valid) begin
        chk({tag, "_word"}, out_data, v.w[widx]);
        chk({tag, "_last"}, out_last, (widx == 3));
        out_ready = (pi < 8) ? v.ready_pat[pi] : 1'b1;
        pi++;
        flush = v.flush_last && (widx == 3) && out_ready;
        if (out_ready) widx++;
      end else begin
        out_ready = 1'b1;
      end
    end
    chk({tag, "_words_delivered"}, widx, 4);
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b1;
    exp_ent++;
    chk({tag, "_valid_after"}, out_valid, 1'b0);
    chk({tag, "_ent_cnt"}, ent_cnt, exp_ent);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pb;
    int t;
    int got;
    int seen;

    vecs[0].entry = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    vecs[0].ready_pat = 8'hFF; vecs[0].flush_last = 1'b0;
    vecs[0].w[0] = 32'h00112233; vecs[0].w[1] = 32'h44556677;
    vecs[0].w[2] = 32'h8899AABB; vecs[0].w[3] = 32'hCCDDEEFF;

    vecs[1].entry = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
    vecs[1].ready_pat = 8'hF9; vecs[1].flush_last = 1'b0;
    vecs[1].w[0] = 32'hDEADBEEF; vecs[1].w[1] = 32'h01234567;
    vecs[1].w[2] = 32'h89ABCDEF; vecs[1].w[3] = 32'hFEDCBA98;

    vecs[2].entry = 128'h11111111_22222222_33333333_44444444;
    vecs[2].ready_pat = 8'hFF; vecs[2].flush_last = 1'b1;
    vecs[2].w[0] = 32'h11111111; vecs[2].w[1] = 32'h22222222;
    vecs[2].w[2] = 32'h33333333; vecs[2].w[3] = 32'h44444444;

    vecs[3].entry = 128'hFFFFFFFF_00000000_A5A5A5A5_5A5A5A5A;
    vecs[3].ready_pat = 8'hAA; vecs[3].flush_last = 1'b0;
    vecs[3].w[0] = 32'hFFFFFFFF; vecs[3].w[1] = 32'h00000000;
    vecs[3].w[2] = 32'hA5A5A5A5; vecs[3].w[3] = 32'h5A5A5A5A;

    rst_n = 1'b0; out_ready = 1'b1; flush = 1'b0; out_ready2 = 1'b1; flush2 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state, with an entry already waiting in the queue.
    push(vecs[0].entry);
    #1;
    chk("rst_q_rd_en", q_rd_en, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_ent_cnt", ent_cnt, 16'h0);
    chk("rst_ent_cnt2", ent_cnt2, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_no_rd_en", q_rd_en, 1'b0);

    // Table: one entry per vector.
    for (int i = 0; i < 4; i++) begin
      pb = pulse_cyc.size();
      if (i != 0) push(vecs[i].entry);
      collect(vecs[i], $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_pops", i), pulse_cyc.size(), pb + 1);
      chk($sformatf("vec%0d_stat", i), q_rd_stat, 8'd0);
    end

    // Three queued entries drained back to back with out_ready high.
    pb = pulse_cyc.size();
    for (int k = 0; k < 3; k++) push({wb(k, 0), wb(k, 1), wb(k, 2), wb(k, 3)});
    got = 0; t = 0;
    while (got < 12 && t < 200) begin
      @(negedge clk);
      t++;
      if (out_valid) begin
        chk("burst_word", out_data, wb(got / 4, got % 4));
        chk("burst_last", out_last, (got % 4) == 3);
        got++;
      end
    end
    chk("burst_words", got, 12);
    repeat (20) @(negedge clk);
    exp_ent += 3;
    chk("burst_pops", pulse_cyc.size(), pb + 3);
    chk("burst_ent_cnt", ent_cnt, exp_ent);
    if (pulse_cyc.size() >= pb + 3) begin
      chk("burst_gap01", pulse_cyc[pb + 1] - pulse_cyc[pb], 6);
      chk("burst_gap12", pulse_cyc[pb + 2] - pulse_cyc[pb + 1], 6);
    end

    // Flush in SEND after word 1 is accepted, then a fresh entry.
    push(128'h0A0B0C0D_1A1B1C1D_2A2B2C2D_3A3B3C3D);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 20);
    chk("fs_word0", out_data, 32'h0A0B0C0D);
    @(negedge clk);
    chk("fs_word1", out_data, 32'h1A1B1C1D);
    @(negedge clk);
    chk("fs_word2", out_data, 32'h2A2B2C2D);
    flush = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1;
    chk("fs_valid_dropped", out_valid, 1'b0);
    chk("fs_ent_cnt", ent_cnt, exp_ent);
    push(vecs[1].entry);
    collect(vecs[1], "fs_next");

    // Flush in WAIT: the read completes but nothing is delivered.
    pb = pulse_cyc.size();
    push(128'h55555555_66666666_77777777_88888888);
    @(negedge clk);
    chk("fw_rd_en_in_wait", q_rd_en, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("fw_no_valid", seen, 0);
    chk("fw_pops", pulse_cyc.size(), pb + 1);
    chk("fw_ent_cnt", ent_cnt, exp_ent);

    // Reset pulse in WAIT, then two queued entries drain normally.
    push(128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rw_q_rd_en", q_rd_en, 1'b0);
    chk("rw_out_valid", out_valid, 1'b0);
    chk("rw_out_data", out_data, 32'h0);
    chk("rw_out_last", out_last, 1'b0);
    chk("rw_ent_cnt", ent_cnt, 16'h0);
    exp_ent = 0;
    push(vecs[2].entry);
    push(vecs[0].entry);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rw_release_no_rd_en", q_rd_en, 1'b0);
    pb = pulse_cyc.size();
    collect(vecs[2], "rw_e0");
    collect(vecs[0], "rw_e1");
    chk("rw_pops", pulse_cyc.size(), pb + 2);

    // Latency-3 instance: 17 entries, counter saturates at 0xF.
    begin
      int done = 0;
      int words = 0;
      n_push2 = 17;
      t = 0;
      while (words < 68 && t < 400) begin
        @(negedge clk);
        t++;
        chk("l3_ent_cnt_track", ent_cnt2, (done > 15) ? 15 : done);
        if (out_valid2) begin
          chk("l3_word", out_data2, w2(words / 4, words % 4));
          chk("l3_last", out_last2, (words % 4) == 3);
          if ((words % 4) == 3) done++;
          words++;
        end
      end
      chk("l3_words", words, 68);
      @(negedge clk);
      chk("l3_ent_cnt_sat", ent_cnt2, 4'hF);
    end

    chk("rd_en_when_empty", en_empty, 0);
    chk("rd_en_back_to_back", back2back, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
